// File: rtl/alu_collect_pkg.sv
// Shared types, command codes and operand-requirement decoding for the ALU
// operand collector.
package alu_collect_pkg;

    localparam int CMD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        ISSUE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        TMO  = 2'b01,
        ILL  = 2'b10,
        OVR  = 2'b11
    } err_e;

    // Arithmetic table (MODE = 1)
    localparam logic [CMD_W-1:0] A_ADD     = 4'd0;
    localparam logic [CMD_W-1:0] A_SUB     = 4'd1;
    localparam logic [CMD_W-1:0] A_ADD_CIN = 4'd2;
    localparam logic [CMD_W-1:0] A_SUB_CIN = 4'd3;
    localparam logic [CMD_W-1:0] A_INC_A   = 4'd4;
    localparam logic [CMD_W-1:0] A_DEC_A   = 4'd5;
    localparam logic [CMD_W-1:0] A_INC_B   = 4'd6;
    localparam logic [CMD_W-1:0] A_DEC_B   = 4'd7;
    localparam logic [CMD_W-1:0] A_CMP     = 4'd8;
    localparam logic [CMD_W-1:0] A_MUL_INC = 4'd9;
    localparam logic [CMD_W-1:0] A_MUL_SHL = 4'd10;

    // Logical table (MODE = 0)
    localparam logic [CMD_W-1:0] L_AND     = 4'd0;
    localparam logic [CMD_W-1:0] L_NAND    = 4'd1;
    localparam logic [CMD_W-1:0] L_OR      = 4'd2;
    localparam logic [CMD_W-1:0] L_NOR     = 4'd3;
    localparam logic [CMD_W-1:0] L_XOR     = 4'd4;
    localparam logic [CMD_W-1:0] L_XNOR    = 4'd5;
    localparam logic [CMD_W-1:0] L_NOT_A   = 4'd6;
    localparam logic [CMD_W-1:0] L_NOT_B   = 4'd7;
    localparam logic [CMD_W-1:0] L_SHR1_A  = 4'd8;
    localparam logic [CMD_W-1:0] L_SHL1_A  = 4'd9;
    localparam logic [CMD_W-1:0] L_SHR1_B  = 4'd10;
    localparam logic [CMD_W-1:0] L_SHL1_B  = 4'd11;
    localparam logic [CMD_W-1:0] L_ROL     = 4'd12;
    localparam logic [CMD_W-1:0] L_ROR     = 4'd13;

    function automatic logic needs_a(input logic mode, input logic [CMD_W-1:0] cmd);
        logic r;
        if (mode) begin
            case (cmd)
                A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_INC_A, A_DEC_A,
                A_CMP, A_MUL_INC, A_MUL_SHL: r = 1'b1;
                default:                     r = 1'b0;
            endcase
        end else begin
            case (cmd)
                L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_NOT_A,
                L_SHR1_A, L_SHL1_A, L_ROL, L_ROR: r = 1'b1;
                default:                          r = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic needs_b(input logic mode, input logic [CMD_W-1:0] cmd);
        logic r;
        if (mode) begin
            case (cmd)
                A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_INC_B, A_DEC_B,
                A_CMP, A_MUL_INC, A_MUL_SHL: r = 1'b1;
                default:                     r = 1'b0;
            endcase
        end else begin
            case (cmd)
                L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_NOT_B,
                L_SHR1_B, L_SHL1_B, L_ROL, L_ROR: r = 1'b1;
                default:                          r = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic cmd_legal(input logic mode, input logic [CMD_W-1:0] cmd);
        logic r;
        if (mode) begin
            r = (cmd <= A_MUL_SHL);
        end else begin
            r = (cmd <= L_ROR);
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_timeout_counter.sv
// Counts CE-qualified wait cycles after a partial operand beat; expire is
// asserted combinationally during the TIMEOUT-th enabled cycle.
module alu_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_r;

    // Wait-cycle counter; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = enable && (count_r == W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_operand_collector.sv
// Collects split-beat ALU operands, checks commands and hands one complete
// operation per valid/ready handshake to the execute stage.
module alu_operand_collector
    import alu_collect_pkg::*;
#(
    parameter int N       = 8,
    parameter int M       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic [1:0]   INP_VALID,
    input  logic [N-1:0] OPA,
    input  logic [N-1:0] OPB,
    input  logic [M-1:0] CMD,
    input  logic         MODE,
    input  logic         CIN,
    output logic         in_ready,
    output logic         issue_valid,
    input  logic         issue_ready,
    output logic [N-1:0] issue_opa,
    output logic [N-1:0] issue_opb,
    output logic [M-1:0] issue_cmd,
    output logic         issue_mode,
    output logic         issue_cin,
    output logic         ERR,
    output logic [1:0]   err_code
);

    state_e       state_r, state_s;
    err_e         err_s;
    logic         got_a_r, got_b_r, need_a_r, need_b_r;
    logic         got_a_s, got_b_s, need_a_s, need_b_s;
    logic [N-1:0] opa_s, opb_s;
    logic [M-1:0] cmd_s;
    logic         mode_s, cin_s;
    logic         beat_s, tmr_clr_s, tmr_en_s, tmr_expire_s;

    assign beat_s   = CE && (INP_VALID != 2'b00);
    assign tmr_en_s = (state_r == WAIT) && CE;
    assign in_ready = (state_r != ISSUE);

    alu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmr (
        .clk    (CLK),
        .rst    (RST),
        .clear  (tmr_clr_s),
        .enable (tmr_en_s),
        .expire (tmr_expire_s)
    );

    // Next-state, capture and error decode.
    always_comb begin
        state_s   = state_r;
        got_a_s   = got_a_r;
        got_b_s   = got_b_r;
        need_a_s  = need_a_r;
        need_b_s  = need_b_r;
        opa_s     = issue_opa;
        opb_s     = issue_opb;
        cmd_s     = issue_cmd;
        mode_s    = issue_mode;
        cin_s     = issue_cin;
        err_s     = NONE;
        tmr_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (beat_s) begin
                    cmd_s     = CMD;
                    mode_s    = MODE;
                    cin_s     = CIN;
                    need_a_s  = needs_a(MODE, CMD);
                    need_b_s  = needs_b(MODE, CMD);
                    got_a_s   = INP_VALID[0] && need_a_s;
                    got_b_s   = INP_VALID[1] && need_b_s;
                    // Operands the command does not use are presented as zero.
                    opa_s     = got_a_s ? OPA : {N{1'b0}};
                    opb_s     = got_b_s ? OPB : {N{1'b0}};
                    tmr_clr_s = 1'b1;
                    if (!cmd_legal(MODE, CMD)) begin
                        err_s   = ILL;
                        state_s = IDLE;
                    end else if ((!need_a_s || got_a_s) && (!need_b_s || got_b_s)) begin
                        state_s = ISSUE;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (CE) begin
                    if (INP_VALID[0] && need_a_r) begin
                        opa_s   = OPA;
                        got_a_s = 1'b1;
                    end else begin
                        got_a_s = got_a_r;
                    end
                    if (INP_VALID[1] && need_b_r) begin
                        opb_s   = OPB;
                        got_b_s = 1'b1;
                    end else begin
                        got_b_s = got_b_r;
                    end
                    // Completion in the last allowed cycle beats the timeout.
                    if ((!need_a_r || got_a_s) && (!need_b_r || got_b_s)) begin
                        state_s   = ISSUE;
                        tmr_clr_s = 1'b1;
                    end else if (tmr_expire_s) begin
                        err_s     = TMO;
                        state_s   = IDLE;
                        tmr_clr_s = 1'b1;
                        got_a_s   = 1'b0;
                        got_b_s   = 1'b0;
                        need_a_s  = 1'b0;
                        need_b_s  = 1'b0;
                        opa_s     = {N{1'b0}};
                        opb_s     = {N{1'b0}};
                        cmd_s     = {M{1'b0}};
                        mode_s    = 1'b0;
                        cin_s     = 1'b0;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            ISSUE: begin
                if (beat_s) begin
                    err_s = OVR;
                end else begin
                    err_s = NONE;
                end
                // The downstream handshake is not gated by CE: it belongs to
                // the execute-stage interface, not the stimulus interface.
                if (issue_ready) begin
                    state_s = IDLE;
                    got_a_s = 1'b0;
                    got_b_s = 1'b0;
                end else begin
                    state_s = ISSUE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, capture fields and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            got_a_r     <= 1'b0;
            got_b_r     <= 1'b0;
            need_a_r    <= 1'b0;
            need_b_r    <= 1'b0;
            issue_valid <= 1'b0;
            issue_opa   <= {N{1'b0}};
            issue_opb   <= {N{1'b0}};
            issue_cmd   <= {M{1'b0}};
            issue_mode  <= 1'b0;
            issue_cin   <= 1'b0;
            ERR         <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            state_r     <= state_s;
            got_a_r     <= got_a_s;
            got_b_r     <= got_b_s;
            need_a_r    <= need_a_s;
            need_b_r    <= need_b_s;
            issue_valid <= (state_s == ISSUE);
            issue_opa   <= opa_s;
            issue_opb   <= opb_s;
            issue_cmd   <= cmd_s;
            issue_mode  <= mode_s;
            issue_cin   <= cin_s;
            ERR         <= (err_s != NONE);
            err_code    <= err_s;
        end
    end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Scoreboard bench for alu_operand_collector: expected issues and error
// pulses are queued at stimulus time and retired by a negedge monitor.
module tb_alu_operand_collector;

    logic       CLK, RST, CE;
    logic [1:0] INP_VALID;
    logic [7:0] OPA, OPB;
    logic [3:0] CMD;
    logic       MODE, CIN;
    logic       in_ready, issue_valid, issue_ready;
    logic [7:0] issue_opa, issue_opb;
    logic [3:0] issue_cmd;
    logic       issue_mode, issue_cin, ERR;
    logic [1:0] err_code;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] c;
        logic       m;
        logic       ci;
        int         cyc;
    } iss_t;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } err_t;

    iss_t        iq[$];
    err_t        eq[$];
    iss_t        me;
    err_t        mr;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          t;
    logic        prev_valid = 1'b0;
    logic        hold_v = 1'b0;
    logic [21:0] hold_snap;

    alu_operand_collector #(.N(8), .M(4), .TIMEOUT(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .CE          (CE),
        .INP_VALID   (INP_VALID),
        .OPA         (OPA),
        .OPB         (OPB),
        .CMD         (CMD),
        .MODE        (MODE),
        .CIN         (CIN),
        .in_ready    (in_ready),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_opa   (issue_opa),
        .issue_opb   (issue_opb),
        .issue_cmd   (issue_cmd),
        .issue_mode  (issue_mode),
        .issue_cin   (issue_cin),
        .ERR         (ERR),
        .err_code    (err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_iss(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                            input logic m, input logic ci, input int at);
        iss_t e;
        e.a = a; e.b = b; e.c = c; e.m = m; e.ci = ci; e.cyc = at;
        iq.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code, input int at);
        err_t e;
        e.code = code; e.cyc = at;
        eq.push_back(e);
    endtask

    task automatic drive(input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c, input logic m, input logic ci);
        INP_VALID = iv; OPA = a; OPB = b; CMD = c; MODE = m; CIN = ci;
        @(posedge CLK); #1;
        INP_VALID = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    // Monitor: latency on issue rise, payload on handshake, stability while stalled, error pulses.
    always @(negedge CLK) begin
        if (RST) begin
            prev_valid = 1'b0;
            hold_v     = 1'b0;
        end else begin
            if (hold_v && issue_valid)
                chk("hold", 32'({issue_opa, issue_opb, issue_cmd, issue_mode, issue_cin}), 32'(hold_snap));
            hold_v    = issue_valid && !issue_ready;
            hold_snap = {issue_opa, issue_opb, issue_cmd, issue_mode, issue_cin};
            if (issue_valid && !prev_valid) begin
                if (iq.size() == 0) chk("iss_unexp", 32'(issue_valid), 32'd0);
                else                chk("iss_lat", 32'(cyc), 32'(iq[0].cyc));
            end
            if (issue_valid && issue_ready && iq.size() != 0) begin
                me = iq.pop_front();
                chk("iss_opa",  32'(issue_opa),  32'(me.a));
                chk("iss_opb",  32'(issue_opb),  32'(me.b));
                chk("iss_cmd",  32'(issue_cmd),  32'(me.c));
                chk("iss_mode", 32'(issue_mode), 32'(me.m));
                chk("iss_cin",  32'(issue_cin),  32'(me.ci));
            end
            prev_valid = issue_valid;
            if (ERR) begin
                if (eq.size() == 0) begin
                    chk("err_unexp", 32'(ERR), 32'd0);
                end else begin
                    mr = eq.pop_front();
                    chk("err_code", 32'(err_code), 32'(mr.code));
                    chk("err_cyc",  32'(cyc), 32'(mr.cyc));
                end
            end else begin
                chk("err_quiet", 32'(err_code), 32'd0);
            end
        end
    end

    initial begin
        RST = 1'b1; CE = 1'b1; INP_VALID = 2'b00; OPA = 8'h00; OPB = 8'h00;
        CMD = 4'h0; MODE = 1'b0; CIN = 1'b0; issue_ready = 1'b1;
        idle(3);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_err",   32'(ERR), 32'd0);
        chk("rst_code",  32'(err_code), 32'd0);
        chk("rst_opa",   32'(issue_opa), 32'd0);
        chk("rst_rdy",   32'(in_ready), 32'd1);
        RST = 1'b0;
        idle(1);

        // 1: both operands in one beat
        t = cyc;
        push_iss(8'h12, 8'h34, 4'd0, 1'b1, 1'b0, t + 1);
        drive(2'b11, 8'h12, 8'h34, 4'd0, 1'b1, 1'b0);
        idle(2);

        // 2: split beats, CMD/MODE/CIN changes in WAIT ignored
        t = cyc;
        push_iss(8'h05, 8'h07, 4'd0, 1'b1, 1'b0, t + 5);
        drive(2'b01, 8'h05, 8'hAA, 4'd0, 1'b1, 1'b0);
        idle(3);
        drive(2'b10, 8'h99, 8'h07, 4'd9, 1'b0, 1'b1);
        idle(2);

        // 3: timeout after 16 idle wait cycles
        t = cyc;
        push_err(2'b01, t + 17);
        drive(2'b01, 8'h11, 8'h00, 4'd1, 1'b1, 1'b0);
        idle(16);
        chk("tmo_rdy",   32'(in_ready), 32'd1);
        chk("tmo_noiss", 32'(issue_valid), 32'd0);
        idle(2);

        // 3 variant: completion in the 16th wait cycle wins
        drive(2'b01, 8'h21, 8'h00, 4'd2, 1'b1, 1'b1);
        idle(15);
        t = cyc;
        push_iss(8'h21, 8'h43, 4'd2, 1'b1, 1'b1, t + 1);
        drive(2'b10, 8'h00, 8'h43, 4'd2, 1'b1, 1'b1);
        idle(2);

        // 4: single-operand commands zero the unused operand; illegal commands
        t = cyc;
        push_iss(8'hFF, 8'h00, 4'd4, 1'b1, 1'b0, t + 1);
        drive(2'b01, 8'hFF, 8'h55, 4'd4, 1'b1, 1'b0);
        idle(1);
        t = cyc;
        push_iss(8'h00, 8'h88, 4'd6, 1'b1, 1'b0, t + 1);
        drive(2'b11, 8'h77, 8'h88, 4'd6, 1'b1, 1'b0);
        idle(1);
        t = cyc;
        push_err(2'b10, t + 1);
        drive(2'b11, 8'h01, 8'h02, 4'd15, 1'b0, 1'b0);
        idle(1);
        chk("ill_rdy", 32'(in_ready), 32'd1);
        t = cyc;
        push_err(2'b10, t + 1);
        drive(2'b11, 8'h01, 8'h02, 4'd11, 1'b1, 1'b0);
        idle(1);
        t = cyc;
        push_iss(8'hC3, 8'h3C, 4'd13, 1'b0, 1'b1, t + 1);
        drive(2'b11, 8'hC3, 8'h3C, 4'd13, 1'b0, 1'b1);
        idle(2);

        // 5: stalled issue, overrun beat, then release and back-to-back beat
        issue_ready = 1'b0;
        t = cyc;
        push_iss(8'hA1, 8'hB2, 4'd3, 1'b1, 1'b1, t + 1);
        drive(2'b11, 8'hA1, 8'hB2, 4'd3, 1'b1, 1'b1);
        chk("iss_rdy_lo", 32'(in_ready), 32'd0);
        push_err(2'b11, t + 2);
        drive(2'b11, 8'h0F, 8'hF0, 4'd1, 1'b1, 1'b0);
        idle(2);
        issue_ready = 1'b1;
        idle(1);
        chk("hs_rdy", 32'(in_ready), 32'd1);
        t = cyc;
        push_iss(8'h0F, 8'hF0, 4'd1, 1'b0, 1'b0, t + 1);
        drive(2'b11, 8'h0F, 8'hF0, 4'd1, 1'b0, 1'b0);
        idle(2);

        // 6: timer frozen under CE=0, then reset mid-wait
        drive(2'b01, 8'h31, 8'h00, 4'd0, 1'b1, 1'b0);
        CE = 1'b0;
        idle(20);
        CE = 1'b1;
        idle(7);
        RST = 1'b1;
        idle(1);
        chk("mrst_valid", 32'(issue_valid), 32'd0);
        chk("mrst_err",   32'(ERR), 32'd0);
        chk("mrst_opa",   32'(issue_opa), 32'd0);
        chk("mrst_cmd",   32'(issue_cmd), 32'd0);
        chk("mrst_rdy",   32'(in_ready), 32'd1);
        RST = 1'b0;
        t = cyc;
        push_iss(8'h66, 8'h99, 4'd2, 1'b0, 1'b1, t + 1);
        drive(2'b11, 8'h66, 8'h99, 4'd2, 1'b0, 1'b1);
        idle(20);

        chk("iq_empty", 32'(iq.size()), 32'd0);
        chk("eq_empty", 32'(eq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
